// File: rtl/alu_sched_if.sv
// Request/response bus for alu_sched: two ALU requesters, one response port and the architectural flags.
// The slave modport is the scheduler side; the master modport is the requester/consumer side.
interface alu_sched_if;
    logic        req0_valid;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_ready;

    logic        req1_valid;
    logic        req1_op;
    logic [1:0]  req1_cond;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_ready;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_wr;

    logic        c_flag;
    logic        z_flag;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_cond, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_wr,
        input  rsp_ready,
        output c_flag, z_flag
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_cond, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_wr,
        output rsp_ready,
        input  c_flag, z_flag
    );
endinterface

// File: rtl/alu_sched.sv
// Two-requester ALU scheduler: arbitrate in IDLE, compute in EXEC, hold the response in RESP.
// Optional macro ALU_SCHED_RR_ARB_EN selects round-robin arbitration instead of fixed req1 priority.
module alu_sched (
    input  logic         clk,
    input  logic         rst_n,
    alu_sched_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_op;
    logic [1:0]  r_cond;
    logic        r_id;
    logic [15:0] r_rsp_result;
    logic        r_rsp_wr;
    logic        r_rsp_id;
    logic        r_c;
    logic        r_z;

    logic        w_prio1;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_req0_ready;
    logic        w_req1_ready;
    logic        w_handshake;
    logic [16:0] w_sum;
    logic [15:0] w_result;
    logic        w_cond_ok;

`ifdef ALU_SCHED_RR_ARB_EN
    // 0 = last grant went to req0, so req1 wins the next contention.
    logic        r_last;

    assign w_prio1 = ~r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b0;
        end else if (w_handshake) begin
            r_last <= w_grant1;
        end
    end
`else
    assign w_prio1 = 1'b1;
`endif

    assign w_grant1 = bus.req1_valid & (~bus.req0_valid | w_prio1);
    assign w_grant0 = bus.req0_valid & ~w_grant1;

    always_comb begin
        w_state_next = r_state;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE: begin
                w_req0_ready = w_grant0;
                w_req1_ready = w_grant1;
                if (w_grant0 || w_grant1) begin
                    w_handshake  = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_result = r_op ? ~(r_a & r_b) : w_sum[15:0];

    // Flags are sampled as they stand during EXEC, before this operation updates them.
    always_comb begin
        w_cond_ok = 1'b1;
        case (r_cond)
            2'b01:   w_cond_ok = r_c;
            2'b10:   w_cond_ok = r_z;
            default: w_cond_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= 16'h0000;
            r_b          <= 16'h0000;
            r_op         <= 1'b0;
            r_cond       <= 2'b00;
            r_id         <= 1'b0;
            r_rsp_result <= 16'h0000;
            r_rsp_wr     <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_c          <= 1'b0;
            r_z          <= 1'b0;
        end else begin
            if (w_handshake) begin
                // req0 is forced to an unconditional ADD.
                r_id   <= w_grant1;
                r_op   <= w_grant1 ? bus.req1_op   : 1'b0;
                r_cond <= w_grant1 ? bus.req1_cond : 2'b00;
                r_a    <= w_grant1 ? bus.req1_a    : bus.req0_a;
                r_b    <= w_grant1 ? bus.req1_b    : bus.req0_b;
            end
            if (r_state == EXEC) begin
                r_rsp_result <= w_result;
                r_rsp_wr     <= w_cond_ok;
                r_rsp_id     <= r_id;
                if (r_id && w_cond_ok) begin
                    r_z <= (w_result == 16'h0000);
                    if (!r_op) begin
                        r_c <= w_sum[16];
                    end
                end
            end
        end
    end

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_wr     = r_rsp_wr;
    assign bus.c_flag     = r_c;
    assign bus.z_flag     = r_z;
endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched: flag arithmetic, conditions, arbitration, stall and reset abort.
// Build with ALU_SCHED_RR_ARB_EN defined to check the round-robin grant order.
module tb_alu_sched;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    alu_sched_if bus ();

    alu_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered in the low clock phase with the DUT in IDLE; leaves in the low phase back in IDLE.
    task automatic txn(input int rq, input logic op, input logic [1:0] cond,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_res,
                       input logic exp_wr, input logic exp_c, input logic exp_z);
        if (rq == 1) begin
            bus.req1_valid = 1'b1;
            bus.req1_op    = op;
            bus.req1_cond  = cond;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("grant0", 16'(bus.req0_ready), 16'(rq == 0));
        chk("grant1", 16'(bus.req1_ready), 16'(rq == 1));
        @(posedge clk);
        @(negedge clk);
        chk("exec_no_rsp", 16'(bus.rsp_valid), 16'd0);
        chk("exec_no_grant", 16'(bus.req0_ready | bus.req1_ready), 16'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid", 16'(bus.rsp_valid), 16'd1);
        chk("rsp_id", 16'(bus.rsp_id), 16'(rq));
        chk("rsp_result", bus.rsp_result, exp_res);
        chk("rsp_wr", 16'(bus.rsp_wr), 16'(exp_wr));
        chk("c_flag", 16'(bus.c_flag), 16'(exp_c));
        chk("z_flag", 16'(bus.z_flag), 16'(exp_z));
        chk("resp_no_grant", 16'(bus.req0_ready | bus.req1_ready), 16'd0);
        $display("txn req%0d a=%h b=%h -> result=%h wr=%b id=%b C=%b Z=%b", rq, a, b,
                 bus.rsp_result, bus.rsp_wr, bus.rsp_id, bus.c_flag, bus.z_flag);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_no_rsp", 16'(bus.rsp_valid), 16'd0);
    endtask

    // Both requesters valid: req0 = 1+1, req1 = ADD 0x10+0x20 cond 00.
    task automatic cont(input int exp_id, input int stall);
        logic [15:0] exp_res;
        exp_res = (exp_id == 1) ? 16'h0030 : 16'h0002;
        bus.req0_valid = 1'b1;
        bus.req0_a     = 16'h0001;
        bus.req0_b     = 16'h0001;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 1'b0;
        bus.req1_cond  = 2'b00;
        bus.req1_a     = 16'h0010;
        bus.req1_b     = 16'h0020;
        bus.rsp_ready  = (stall == 0);
        #1;
        chk("arb_grant1", 16'(bus.req1_ready), 16'(exp_id == 1));
        chk("arb_grant0", 16'(bus.req0_ready), 16'(exp_id == 0));
        @(posedge clk);
        @(negedge clk);
        chk("arb_exec_no_rsp", 16'(bus.rsp_valid), 16'd0);
        @(posedge clk);
        @(negedge clk);
        chk("arb_rsp_valid", 16'(bus.rsp_valid), 16'd1);
        chk("arb_rsp_id", 16'(bus.rsp_id), 16'(exp_id));
        chk("arb_rsp_result", bus.rsp_result, exp_res);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 16'(bus.rsp_valid), 16'd1);
            chk("stall_id", 16'(bus.rsp_id), 16'(exp_id));
            chk("stall_result", bus.rsp_result, exp_res);
            chk("stall_wr", 16'(bus.rsp_wr), 16'd1);
            chk("stall_no_grant", 16'(bus.req0_ready | bus.req1_ready), 16'd0);
        end
        $display("txn contention -> id=%b result=%h stall=%0d", bus.rsp_id, bus.rsp_result, stall);
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("arb_idle_no_rsp", 16'(bus.rsp_valid), 16'd0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_a     = 16'h0000;
        bus.req0_b     = 16'h0000;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 1'b0;
        bus.req1_cond  = 2'b00;
        bus.req1_a     = 16'h0000;
        bus.req1_b     = 16'h0000;
        bus.rsp_ready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("rst_rsp_id", 16'(bus.rsp_id), 16'd0);
        chk("rst_rsp_wr", 16'(bus.rsp_wr), 16'd0);
        chk("rst_rsp_result", bus.rsp_result, 16'h0000);
        chk("rst_c", 16'(bus.c_flag), 16'd0);
        chk("rst_z", 16'(bus.z_flag), 16'd0);
        chk("rst_no_grant", 16'(bus.req0_ready | bus.req1_ready), 16'd0);
        rst_n = 1'b1;

        @(negedge clk);
        txn(1, 1'b0, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0);
        txn(1, 1'b0, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1);
        txn(1, 1'b0, 2'b01, 16'h0002, 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0);
        txn(1, 1'b0, 2'b01, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0, 1'b0);
        txn(1, 1'b1, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
        txn(1, 1'b0, 2'b10, 16'h0001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0);
        txn(1, 1'b1, 2'b10, 16'h0F0F, 16'h00FF, 16'hFFF0, 1'b0, 1'b0, 1'b0);
        txn(1, 1'b0, 2'b11, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b1, 1'b0);
        txn(0, 1'b0, 2'b00, 16'h00FF, 16'hFF01, 16'h0000, 1'b1, 1'b1, 1'b0);

`ifdef ALU_SCHED_RR_ARB_EN
        cont(1, 3);
        cont(0, 0);
        cont(1, 0);
        cont(0, 0);
`else
        cont(1, 3);
        cont(1, 0);
        cont(1, 0);
        cont(1, 0);
`endif
        chk("post_arb_c", 16'(bus.c_flag), 16'd0);
        chk("post_arb_z", 16'(bus.z_flag), 16'd0);

        // Abort a NAND whose result would set Z by pulsing reset during EXEC.
        bus.req1_valid = 1'b1;
        bus.req1_op    = 1'b1;
        bus.req1_cond  = 2'b00;
        bus.req1_a     = 16'hFFFF;
        bus.req1_b     = 16'hFFFF;
        #1;
        chk("abort_grant", 16'(bus.req1_ready), 16'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        chk("abort_exec_no_rsp", 16'(bus.rsp_valid), 16'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_rst_no_rsp", 16'(bus.rsp_valid), 16'd0);
        chk("abort_rst_z", 16'(bus.z_flag), 16'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("abort_release_no_rsp", 16'(bus.rsp_valid), 16'd0);
        $display("txn reset abort during EXEC");
        txn(0, 1'b0, 2'b00, 16'h1234, 16'h0001, 16'h1235, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 The block SHALL have exactly one clock and one reset, reset being asynchronous and active-low:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-002 Requester 0 (fetch, PC increment) SHALL use these ports:
- req0_valid  in  1  request pending
- req0_a, req0_b  in  16  operands, always added
- req0_ready  out  1  grant; handshake completes when valid and ready are both high
REQ-003 Requester 1 (execute) SHALL use these ports:
- req1_valid  in  1  request pending
- req1_op  in  1  0=ADD, 1=NAND
- req1_cond  in  2  00 always, 01 if C, 10 if Z, 11 treated as always
- req1_a, req1_b  in  16  operands
- req1_ready  out  1  grant
REQ-004 The response and flag outputs SHALL be:
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  consumer accept
- rsp_id  out  1  granted requester
- rsp_result  out  16  ALU result
- rsp_wr  out  1  destination write enable
- c_flag, z_flag  out  1  architectural carry and zero flags

Function
REQ-005 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-006 IDLE: req0_ready/req1_ready SHALL be asserted only in IDLE, combinationally, and only for the arbitration winner; at most one SHALL be high.
REQ-007 Arbitration (default): when both are valid, req1 SHALL win; a lone valid requester SHALL always win.
REQ-008 On handshake, the block SHALL capture the operands, op, cond and id, and move IDLE->EXEC; with no valid request it SHALL stay in IDLE.
REQ-009 EXEC (one cycle), ADD: the sum SHALL be computed 17 bits wide from zero-extended operands; result = sum[15:0]; carry = sum[16].
REQ-010 EXEC, NAND: result SHALL be ~(a&b); carry SHALL be unaffected.
REQ-011 Condition SHALL be evaluated against c_flag/z_flag as they stand in EXEC; cond_ok = 1 for 00 and 11.
REQ-012 Flag update rules:
- Requester 1 with cond_ok: z_flag <= (result==0); for ADD also c_flag <= sum[16].
- Requester 0, or cond_ok=0: flags SHALL be unchanged.
- Flags SHALL update at the EXEC->RESP edge.
REQ-013 EXEC->RESP SHALL be unconditional. rsp_result SHALL be registered, and rsp_wr = cond_ok (always 1 for requester 0).
REQ-014 RESP: rsp_valid=1 with rsp_id/rsp_result/rsp_wr held stable until rsp_ready=1, then RESP->IDLE; rsp_ready SHALL be ignored outside RESP.
REQ-015 Latency: handshake at edge N SHALL give rsp_valid at edge N+2; minimum issue interval 3 cycles; no new grant while in EXEC or RESP.
REQ-016 Overflow beyond 16 bits SHALL be discarded in rsp_result; 0xFFFF+0x0001 gives result 0x0000, C=1, Z=1.

Reset
REQ-017 While rst_n=0: state=IDLE; rsp_valid, rsp_id, rsp_wr, c_flag, z_flag = 0; rsp_result = 0x0000; arbitration pointer = 0.
REQ-018 Reset asserted in EXEC or RESP SHALL discard the transaction, with no flag update and no response after release.
REQ-019 The first IDLE cycle after release SHALL be able to grant.

Configuration
REQ-020 Macro ALU_SCHED_RR_ARB_EN:
- Defined: round-robin arbitration using a 1-bit last-grant register (reset 0 = "last was req0"); on contention, grant the requester not granted last; the register updates on every handshake.
- Undefined: fixed priority per REQ-007, and no pointer register.

Verification
REQ-021 Required directed scenarios:
- Reset, then req1 ADD 0x7FFF+0x0001, cond 00 -> rsp at N+2: result 0x8000, wr=1, C=0, Z=0, id=1.
- req1 ADD 0xFFFF+0x0001 -> result 0x0000, C=1, Z=1; next req1 ADD cond 01 0x0002+0x0003 -> result 0x0005, wr=1, C=0, Z=0.
- Flags C=0, then req1 ADD cond 01 0x0010+0x0020 -> result 0x0030, wr=0, flags unchanged.
- C=1, Z=0, then req0 0x00FF+0xFF01 -> result 0x0000, wr=1, id=0, C=1, Z=0 unchanged.
- Both valid for 4 transactions -> default build: ids 1,1,1,1; with ALU_SCHED_RR_ARB_EN: ids 1,0,1,0; rsp_ready held low for 3 cycles -> rsp fields stable, no grant.
- rst_n pulsed low during EXEC of req1 NAND 0xFFFF,0xFFFF -> no rsp_valid, Z stays 0, the next grant is available in the first IDLE cycle.
